// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc
// Multi-cycle register-file + ALU datapath. It executes one instruction per
// start pulse and sits between the controller and the memory/cache.
// Sequence: IDLE -> EXEC -> (MEM) -> WB -> IDLE.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start                 issue the operation on the control inputs (IDLE only)
//   busy / done           busy outside IDLE; done is a one-cycle pulse in WB
//   RS1, RS2, RD          register indices
//   IMM                   signed immediate
//   ALUControl            ALU operation select
//   ALUSrc                1: SrcB = IMM, 0: SrcB = reg[RS2]
//   MemRead, MemWrite     memory operation controls (both set = store)
//   RegWrite, link        writeback enable, write pclink instead of the result
//   pclink                value written to RD when link = 1
//   Zero, Neg, Carry      registered ALU flags, updated only in EXEC
//   PCReg                 reg[RS1] captured in EXEC
//   mem_req, mem_we       memory request and store strobe, held through MEM
//   Address, WriteData    word address (ALUResult[NBITS-1:2]) and store data
//   ReadData, mem_ready   load data and completion strobe from memory
// -----------------------------------------------------------------------------
module datapath_mc #(
   parameter int NBITS      = 8,
   parameter int NREGS      = 32,
   parameter int WIDTH_ALUF = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic [$clog2(NREGS)-1:0]   RS1,
   input  logic [$clog2(NREGS)-1:0]   RS2,
   input  logic [$clog2(NREGS)-1:0]   RD,
   input  logic [NBITS-1:0]           IMM,
   input  logic [WIDTH_ALUF-1:0]      ALUControl,
   input  logic                       ALUSrc,
   input  logic                       MemRead,
   input  logic                       MemWrite,
   input  logic                       RegWrite,
   input  logic                       link,
   input  logic [NBITS-1:0]           pclink,
   output logic                       Zero,
   output logic                       Neg,
   output logic                       Carry,
   output logic [NBITS-1:0]           PCReg,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [NBITS-3:0]           Address,
   output logic [NBITS-1:0]           WriteData,
   input  logic [NBITS-1:0]           ReadData,
   input  logic                       mem_ready
);

   localparam int RW  = $clog2(NREGS);
   localparam int SHW = $clog2(NBITS);

   localparam logic [WIDTH_ALUF-1:0] ALU_SUB  = WIDTH_ALUF'(4'b1000);
   localparam logic [WIDTH_ALUF-1:0] ALU_AND  = WIDTH_ALUF'(4'b0111);
   localparam logic [WIDTH_ALUF-1:0] ALU_OR   = WIDTH_ALUF'(4'b0110);
   localparam logic [WIDTH_ALUF-1:0] ALU_XOR  = WIDTH_ALUF'(4'b0100);
   localparam logic [WIDTH_ALUF-1:0] ALU_SLT  = WIDTH_ALUF'(4'b0010);
   localparam logic [WIDTH_ALUF-1:0] ALU_SLTU = WIDTH_ALUF'(4'b0011);
   localparam logic [WIDTH_ALUF-1:0] ALU_SLL  = WIDTH_ALUF'(4'b0001);
   localparam logic [WIDTH_ALUF-1:0] ALU_SRL  = WIDTH_ALUF'(4'b0101);
   localparam logic [WIDTH_ALUF-1:0] ALU_SRA  = WIDTH_ALUF'(4'b1101);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MEM  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Operation latched at start so the controller may change its outputs
   // while the datapath is busy.
   logic [RW-1:0]         r_rs1;
   logic [RW-1:0]         r_rs2;
   logic [RW-1:0]         r_rd;
   logic [NBITS-1:0]      r_imm;
   logic [WIDTH_ALUF-1:0] r_aluctl;
   logic                  r_alusrc;
   logic                  r_memread;
   logic                  r_memwrite;
   logic                  r_regwrite;
   logic                  r_link;
   logic [NBITS-1:0]      r_pclink;

   logic [NBITS-1:0]      r_regs [NREGS];
   logic [NBITS-1:0]      r_alu_result;
   logic [NBITS-1:0]      r_load_data;
   logic                  r_zero;
   logic                  r_neg;
   logic                  r_carry;
   logic [NBITS-1:0]      r_pcreg;
   logic [NBITS-1:0]      r_writedata;

   logic [NBITS-1:0]      w_src_a;
   logic [NBITS-1:0]      w_reg_b;
   logic [NBITS-1:0]      w_src_b;
   logic [SHW-1:0]        w_shamt;
   logic [NBITS:0]        w_sum;
   logic [NBITS:0]        w_diff;
   logic [NBITS-1:0]      w_alu_result;
   logic                  w_alu_carry;
   logic [NBITS-1:0]      w_wb_data;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_mem_req;
   logic                  w_mem_we;

   // Register 0 reads as zero regardless of array contents.
   assign w_src_a = (r_rs1 == '0) ? '0 : r_regs[r_rs1];
   assign w_reg_b = (r_rs2 == '0) ? '0 : r_regs[r_rs2];
   assign w_src_b = r_alusrc ? r_imm : w_reg_b;
   assign w_shamt = w_src_b[SHW-1:0];

   // One extra bit captures carry-out on ADD and borrow on SUB.
   assign w_sum  = {1'b0, w_src_a} + {1'b0, w_src_b};
   assign w_diff = {1'b0, w_src_a} - {1'b0, w_src_b};

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_alu_result = w_sum[NBITS-1:0];
      w_alu_carry  = 1'b0;
      case (r_aluctl)
         ALU_SUB: begin
            w_alu_result = w_diff[NBITS-1:0];
            w_alu_carry  = ~w_diff[NBITS];       // set when no borrow
         end
         ALU_AND:  w_alu_result = w_src_a & w_src_b;
         ALU_OR:   w_alu_result = w_src_a | w_src_b;
         ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
         ALU_SLT:  w_alu_result = {{(NBITS-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
         ALU_SLTU: w_alu_result = {{(NBITS-1){1'b0}}, (w_src_a < w_src_b)};
         ALU_SLL:  w_alu_result = w_src_a << w_shamt;
         ALU_SRL:  w_alu_result = w_src_a >> w_shamt;
         ALU_SRA:  w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
         default: begin                           // ADD and all unlisted codes
            w_alu_result = w_sum[NBITS-1:0];
            w_alu_carry  = w_sum[NBITS];
         end
      endcase
   end

   // Both MemRead and MemWrite set is a store, so load data is never used then.
   assign w_wb_data = r_link                     ? r_pclink    :
                      (r_memread && !r_memwrite) ? r_load_data : r_alu_result;

   // Next state and handshake outputs.
   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start) w_next_state = S_EXEC;
         end
         S_EXEC: w_next_state = (r_memread || r_memwrite) ? S_MEM : S_WB;
         S_MEM: begin
            w_mem_req = 1'b1;
            w_mem_we  = r_memwrite;
            if (mem_ready) w_next_state = S_WB;
         end
         S_WB: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the register file is cleared on reset, so it is built from
         // flops with a reset loop rather than mapped onto a RAM macro.
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
         r_rs1        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_imm        <= '0;
         r_aluctl     <= '0;
         r_alusrc     <= 1'b0;
         r_memread    <= 1'b0;
         r_memwrite   <= 1'b0;
         r_regwrite   <= 1'b0;
         r_link       <= 1'b0;
         r_pclink     <= '0;
         r_alu_result <= '0;
         r_load_data  <= '0;
         r_zero       <= 1'b0;
         r_neg        <= 1'b0;
         r_carry      <= 1'b0;
         r_pcreg      <= '0;
         r_writedata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rs1      <= RS1;
                  r_rs2      <= RS2;
                  r_rd       <= RD;
                  r_imm      <= IMM;
                  r_aluctl   <= ALUControl;
                  r_alusrc   <= ALUSrc;
                  r_memread  <= MemRead;
                  r_memwrite <= MemWrite;
                  r_regwrite <= RegWrite;
                  r_link     <= link;
                  r_pclink   <= pclink;
               end
            end
            S_EXEC: begin
               r_alu_result <= w_alu_result;
               r_zero       <= (w_alu_result == '0);
               r_neg        <= w_alu_result[NBITS-1];
               r_carry      <= w_alu_carry;
               r_pcreg      <= w_src_a;
               r_writedata  <= w_reg_b;
            end
            S_MEM: begin
               if (mem_ready) r_load_data <= ReadData;
            end
            S_WB: begin
               if (r_regwrite && (r_rd != '0)) r_regs[r_rd] <= w_wb_data;
            end
            default: ;
         endcase
      end
   end

   assign busy      = w_busy;
   assign done      = w_done;
   assign mem_req   = w_mem_req;
   assign mem_we    = w_mem_we;
   assign Zero      = r_zero;
   assign Neg       = r_neg;
   assign Carry     = r_carry;
   assign PCReg     = r_pcreg;
   assign Address   = r_alu_result[NBITS-1:2];
   assign WriteData = r_writedata;

endmodule
